// File: rtl/roic_stream_gen_pkg.sv
// rtl/roic_stream_gen_pkg.sv - shared types and constants for the ROIC stream emulator
// Purpose: FSM state and pattern enums, LFSR seed, even/odd flag bit position and
//          the interleave helper that maps a sample index to its pixel number.
// Ports:   none (package).
package roic_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BURST = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP      = 2'd0,
    PAT_CONST     = 2'd1,
    PAT_LFSR      = 2'd2,
    PAT_RAMP_RSVD = 2'd3
  } pattern_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          EO_BIT    = 6;

  // Sample c of a k-bit counter carries pixel {c[1:0], c[k-1:2]}; the receiver
  // applies the opposite swizzle so its RAM ends up holding pixels in order.
  function automatic logic [7:0] pixel_of(input logic [7:0] c, input int k);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(c[1:0]) << (k - 2);
    lo = (c >> 2) & 8'((1 << (k - 2)) - 1);
    return hi | lo;
  endfunction

endpackage

// File: rtl/roic_stream_gen_if.sv
// rtl/roic_stream_gen_if.sv - sample stream bundle between the emulator and the reorder buffer
// Purpose: groups the per-sample stream signals.
// Signals: data_out (DATA_WIDTH), valid_out, channel_detected, even_odd, line_done.
// Modports: master drives the stream, slave observes it.
interface roic_stream_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  channel_detected;
  logic                  even_odd;
  logic                  line_done;

  modport master (
    output data_out,
    output valid_out,
    output channel_detected,
    output even_odd,
    output line_done
  );

  modport slave (
    input data_out,
    input valid_out,
    input channel_detected,
    input even_odd,
    input line_done
  );
endinterface

// File: rtl/roic_lfsr16.sv
// rtl/roic_lfsr16.sv - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
// Purpose: pseudo-random payload source for test-pattern generators.
// Ports:   clk, sync_rst (async, active-high) - clock and reset
//          en_i    - advance one step
//          load_i  - load seed_i (has priority over en_i)
//          seed_i  - 16-bit load value
//          state_o - current register contents
module roic_lfsr16
  import roic_stream_pkg::*;
(
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (en_i) begin
      // Taps 16,14,13,11 counted from 1 map to bits 15,13,12,10.
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/roic_stream_gen.sv
// rtl/roic_stream_gen.sv - ROIC line-stream transmitter emulator
// Purpose: emits frames of line bursts in ROIC interleaved order toward the
//          receiver reorder buffer; the even/odd line flag rides on data bit 6.
// Ports:   clk, sync_rst (async, active-high)
//          start       - one-cycle pulse, begins a frame when idle
//          abort       - level, ends the frame at the next burst boundary
//          num_lines   - lines per frame, 0 means 256
//          pattern_sel - 0 ramp, 1 constant, 2 LFSR, 3 ramp
//          const_val   - constant-pattern payload
//          stream      - master side of the sample stream bundle
//          frame_done  - one-cycle pulse at end of frame
//          busy        - frame in progress
module roic_stream_gen
  import roic_stream_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int SAMPLES_PER_CH = 256,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                     clk,
  input  logic                     sync_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               num_lines,
  input  logic [1:0]               pattern_sel,
  input  logic [15:0]              const_val,
  roic_stream_gen_if.master        stream,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int             K      = $clog2(SAMPLES_PER_CH);
  localparam logic [7:0]     C_LAST = 8'(SAMPLES_PER_CH - 1);
  localparam int             GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  G_LAST = GW'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [7:0]             c_q, c_d;
  logic [7:0]             l_q, l_d;
  logic [GW-1:0]          g_q, g_d;
  logic [7:0]             lines_q, lines_d;
  pattern_e               pat_q, pat_d;
  logic [15:0]            cval_q, cval_d;

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   cd_q, cd_d;
  logic                   ld_q, ld_d;
  logic                   fd_q, fd_d;
  logic                   busy_q, busy_d;

  logic [15:0]            lfsr;
  logic [23:0]            payload;
  logic [7:0]             pix;
  logic [8:0]             lines_total;
  logic [8:0]             l_next;

  roic_lfsr16 u_lfsr (
    .clk     (clk),
    .sync_rst(sync_rst),
    .en_i    (state_q == BURST),
    .load_i  (state_q == LOAD),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr)
  );

  assign pix         = pixel_of(c_q, K);
  // A latched count of 0 stands for a full 256-line frame.
  assign lines_total = (lines_q == 8'd0) ? 9'd256 : {1'b0, lines_q};
  assign l_next      = {1'b0, l_q} + 9'd1;

  always_comb begin
    payload = '0;
    case (pat_q)
      PAT_CONST: payload = {cval_q, 1'b0, l_q[0], 6'd0};
      PAT_LFSR:  payload = {lfsr, 1'b0, l_q[0], 6'd0};
      default:   payload = {l_q, pix, 1'b0, l_q[0], 6'd0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    l_d     = l_q;
    g_d     = g_q;
    lines_d = lines_q;
    pat_d   = pat_q;
    cval_d  = cval_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cd_d    = 1'b0;
    ld_d    = 1'b0;
    fd_d    = 1'b0;
    busy_d  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        lines_d = num_lines;
        pat_d   = pattern_e'(pattern_sel);
        cval_d  = const_val;
        c_d     = '0;
        l_d     = '0;
        g_d     = '0;
        state_d = BURST;
      end
      BURST: begin
        valid_d = 1'b1;
        data_d  = DATA_WIDTH'(payload);
        cd_d    = (c_q == 8'd0);
        ld_d    = (c_q == C_LAST);
        if (c_q == C_LAST) begin
          c_d     = '0;
          g_d     = '0;
          state_d = GAP;
        end else begin
          c_d = c_q + 8'd1;
        end
      end
      GAP: begin
        // abort is only looked at here, so a burst is never cut short.
        if (g_q == G_LAST) begin
          if ((l_next < lines_total) && !abort) begin
            l_d     = l_q + 8'd1;
            state_d = BURST;
          end else begin
            state_d = DONE;
          end
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      DONE: begin
        fd_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      l_q     <= '0;
      g_q     <= '0;
      lines_q <= '0;
      pat_q   <= PAT_RAMP;
      cval_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cd_q    <= 1'b0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      l_q     <= l_d;
      g_q     <= g_d;
      lines_q <= lines_d;
      pat_q   <= pat_d;
      cval_q  <= cval_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cd_q    <= cd_d;
      ld_q    <= ld_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign stream.data_out         = data_q;
  assign stream.valid_out        = valid_q;
  assign stream.channel_detected = cd_q;
  assign stream.even_odd         = data_q[EO_BIT];
  assign stream.line_done        = ld_q;
  assign frame_done              = fd_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_roic_stream_gen.sv
// tb/tb_roic_stream_gen.sv - self-checking bench for roic_stream_gen
module tb_roic_stream_gen;

  typedef struct packed {
    logic [23:0] data;
    logic        valid;
    logic        cd;
    logic        eo;
    logic        ld;
    logic        fd;
    logic        busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_lines = 8'd1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] const_val = 16'd0;
  logic        frame_done;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  obs_t        exp_q[$];
  obs_t        act_q[$];
  logic [23:0] model_last = 24'd0;

  roic_stream_gen_if #(.DATA_WIDTH(24)) sif ();

  roic_stream_gen #(
    .DATA_WIDTH    (24),
    .SAMPLES_PER_CH(256),
    .GAP_CYCLES    (4)
  ) dut (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .start      (start),
    .abort      (abort),
    .num_lines  (num_lines),
    .pattern_sel(pattern_sel),
    .const_val  (const_val),
    .stream     (sif),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_now();
    obs_t o;
    o.data  = sif.data_out;
    o.valid = sif.valid_out;
    o.cd    = sif.channel_detected;
    o.eo    = sif.even_odd;
    o.ld    = sif.line_done;
    o.fd    = frame_done;
    o.busy  = busy;
    return o;
  endfunction

  function automatic obs_t quiet(input logic [23:0] d, input logic b);
    obs_t o;
    o       = '0;
    o.data  = d;
    o.eo    = d[6];
    o.busy  = b;
    return o;
  endfunction

  // Expected cycle trace starting with the cycle after the edge that samples start.
  task automatic model_frame(input int pat, input logic [15:0] cv, input int lines);
    logic [15:0] s;
    logic [23:0] d;
    logic [7:0]  lb;
    logic [7:0]  pb;
    obs_t        e;
    exp_q.delete();
    exp_q.push_back(quiet(model_last, 1'b0));
    exp_q.push_back(quiet(model_last, 1'b1));
    s = 16'hACE1;
    for (int l = 0; l < lines; l++) begin
      lb = 8'(l);
      for (int c = 0; c < 256; c++) begin
        pb = 8'((c % 4) * 64 + c / 4);
        case (pat)
          1:       d = {cv, 1'b0, lb[0], 6'd0};
          2:       d = {s, 1'b0, lb[0], 6'd0};
          default: d = {lb, pb, 1'b0, lb[0], 6'd0};
        endcase
        s       = {s[14:0], ^(s & 16'hB400)};
        e       = quiet(d, 1'b1);
        e.valid = 1'b1;
        e.cd    = (c == 0);
        e.ld    = (c == 255);
        exp_q.push_back(e);
        model_last = d;
      end
      for (int g = 0; g < 4; g++) exp_q.push_back(quiet(model_last, 1'b1));
    end
    e    = quiet(model_last, 1'b1);
    e.fd = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(quiet(model_last, 1'b0));
  endtask

  task automatic setup(input int pat, input logic [15:0] cv, input int nl, input int lines);
    pattern_sel = 2'(pat);
    const_val   = cv;
    num_lines   = 8'(nl);
    model_frame(pat, cv, lines);
  endtask

  // Captures exactly as many cycles as the model expects; abort/start injections by cycle index.
  task automatic capture(input int abort_cyc, input int glitch_cyc);
    act_q.delete();
    @(negedge clk);
    start = 1'b1;
    if (abort_cyc == 0) abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      act_q.push_back(sample_now());
      if (k == abort_cyc) abort = 1'b1;
      start = (k == glitch_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    repeat (3) @(negedge clk);
    sync_rst = 1'b0;
    model_last = 24'd0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (sample_now() !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset_state cycle %0d: got %h expected %h", k, sample_now(), obs_t'(0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ramp_two_lines();
    setup(0, 16'h0000, 2, 2);
    capture(-1, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ramp_frame cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (act_q[3].data !== 24'h004000) begin
      n_err++;
      $display("FAIL ramp_sample1 got %h expected %h", act_q[3].data, 24'h004000);
    end
    n_vec++;
    if (act_q[262].data !== 24'h010040 || act_q[262].cd !== 1'b1) begin
      n_err++;
      $display("FAIL ramp_line1_first got %h/%b expected 010040/1", act_q[262].data, act_q[262].cd);
    end
  endtask

  task automatic test_const();
    setup(1, 16'hBEEF, 2, 2);
    capture(-1, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL const_frame cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (act_q[2].data !== 24'hBEEF00 || act_q[262].data !== 24'hBEEF40) begin
      n_err++;
      $display("FAIL const_values got %h,%h expected BEEF00,BEEF40", act_q[2].data, act_q[262].data);
    end
  endtask

  task automatic test_lfsr();
    for (int f = 0; f < 2; f++) begin
      setup(2, 16'h1234, 1, 1);
      capture(-1, -1);
      foreach (exp_q[i]) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL lfsr_frame%0d cycle %0d: got %h expected %h", f, i, act_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if (act_q[2].data[23:8] !== 16'hACE1) begin
        n_err++;
        $display("FAIL lfsr_seed frame%0d got %h expected ace1", f, act_q[2].data[23:8]);
      end
    end
  endtask

  task automatic test_abort();
    setup(0, 16'h0000, 5, 1);
    capture(2 + 100, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL abort_frame cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    setup(1, 16'h5A5A, 3, 1);
    capture(0, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL start_abort cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lines_zero();
    // 0 means 256 lines; abort in line 2 proves the frame did not stop after one line.
    setup(0, 16'h0000, 0, 3);
    capture(2 + 2 * 260 + 10, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL lines_zero cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int          pat;
    int          nl;
    logic [15:0] cv;
    for (int f = 0; f < 3; f++) begin
      pat = $urandom_range(0, 3);
      nl  = $urandom_range(1, 2);
      cv  = 16'($urandom);
      setup(pat, cv, nl, nl);
      capture(-1, -1);
      foreach (exp_q[i]) begin
        n_vec++;
        if (act_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random_frame%0d pat%0d cycle %0d: got %h expected %h", f, pat, i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_glitch_and_reset();
    logic saw_bad;
    // start pulsed at sample 50 must be ignored
    setup(0, 16'h0000, 1, 1);
    capture(-1, 2 + 50);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL start_glitch cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
    // kill a frame at sample 50
    num_lines = 8'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (52) @(negedge clk);
    n_vec++;
    if (sif.valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_valid got %b expected 1", sif.valid_out);
    end
    #2;
    sync_rst = 1'b1;
    #1;
    n_vec++;
    if (sample_now() !== obs_t'(0)) begin
      n_err++;
      $display("FAIL async_reset got %h expected %h", sample_now(), obs_t'(0));
    end
    @(negedge clk);
    sync_rst = 1'b0;
    model_last = 24'd0;
    saw_bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0 || sif.valid_out !== 1'b0) saw_bad = 1'b1;
    end
    n_vec++;
    if (saw_bad !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_quiet got activity=%b expected 0", saw_bad);
    end
    setup(0, 16'h0000, 1, 1);
    capture(-1, -1);
    foreach (exp_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL restart_frame cycle %0d: got %h expected %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_two_lines();
    test_const();
    test_lfsr();
    test_abort();
    test_start_abort_idle();
    test_lines_zero();
    test_random();
    test_start_glitch_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
